// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: commits exceptions/interrupts/ERTN from WB into the CSR file and redirects fetch
// Ports:
//   clk, resetn                      clock, async active-low reset
//   wb_valid, wb_pc, wb_exc, wb_badv, wb_ertn   WB instruction and its {ale,brk,sys,ine,adef} flags
//   int_pending, crmd_ie             masked interrupt vector and global interrupt enable
//   eentry_pc, era_pc                redirect targets for ex/int and ERTN
//   redirect_ready                   IF accepts the redirect
//   wb_retire                        WB instruction commits normally
//   csr_we_block                     suppress WB CSR writes while an event is in flight
//   csr_ex, csr_ertn, csr_ecode, csr_esubcode, csr_ex_pc, csr_badv_we, csr_badv   CSR update pulse and payload
//   flush, redirect_valid, redirect_pc   pipeline kill and fetch redirect handshake
module exc_commit_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int INT_NUM      = 13
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               wb_valid,
    input  logic [31:0]        wb_pc,
    input  logic [4:0]         wb_exc,
    input  logic [31:0]        wb_badv,
    input  logic               wb_ertn,
    input  logic [INT_NUM-1:0] int_pending,
    input  logic               crmd_ie,
    input  logic [31:0]        eentry_pc,
    input  logic [31:0]        era_pc,
    input  logic               redirect_ready,
    output logic               wb_retire,
    output logic               csr_we_block,
    output logic               csr_ex,
    output logic               csr_ertn,
    output logic [5:0]         csr_ecode,
    output logic [8:0]         csr_esubcode,
    output logic [31:0]        csr_ex_pc,
    output logic               csr_badv_we,
    output logic [31:0]        csr_badv,
    output logic               flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc
);
    typedef enum logic [1:0] {IDLE, EVENT, DRAIN, REDIR} state_t;
    localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES + 1) : 1;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          take_int, take_ex, take_ertn, is_ex, badv_hit;
    logic [5:0]    ecode;
    assign take_int     = wb_valid & crmd_ie & |int_pending;
    assign take_ex      = wb_valid & |wb_exc;
    assign take_ertn    = wb_valid & wb_ertn;
    assign is_ex        = take_int | take_ex;
    // wb_exc = {ale,brk,sys,ine,adef}; priority INT > ADEF > INE > SYS > BRK > ALE
    assign ecode        = take_int  ? 6'h00 :
                          wb_exc[0] ? 6'h08 :
                          wb_exc[1] ? 6'h0D :
                          wb_exc[2] ? 6'h0B :
                          wb_exc[3] ? 6'h0C : 6'h09;
    // BADV is written only when ADEF or ALE is the winning cause
    assign badv_hit     = ~take_int & (wb_exc[0] | wb_exc == 5'b10000);
    assign wb_retire    = (state == IDLE) & wb_valid & ~is_ex & ~take_ertn;
    assign csr_we_block = state != IDLE;
    assign csr_esubcode = '0;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            cnt            <= '0;
            csr_ex         <= 1'b0;
            csr_ertn       <= 1'b0;
            csr_ecode      <= '0;
            csr_ex_pc      <= '0;
            csr_badv_we    <= 1'b0;
            csr_badv       <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            case (state)
                IDLE: if (is_ex | take_ertn) begin
                    state       <= EVENT;
                    csr_ex      <= is_ex;
                    csr_ertn    <= ~is_ex;
                    csr_badv_we <= badv_hit;
                    csr_ecode   <= ecode;
                    csr_ex_pc   <= wb_pc;
                    csr_badv    <= wb_badv;
                    redirect_pc <= is_ex ? eentry_pc : era_pc;
                    flush       <= 1'b1;
                end
                EVENT: begin
                    csr_ex         <= 1'b0;
                    csr_ertn       <= 1'b0;
                    csr_badv_we    <= 1'b0;
                    cnt            <= CW'(DRAIN_CYCLES);
                    state          <= DRAIN_CYCLES > 0 ? DRAIN : REDIR;
                    redirect_valid <= DRAIN_CYCLES == 0;
                end
                DRAIN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state          <= REDIR;
                        redirect_valid <= 1'b1;
                    end
                end
                REDIR: if (redirect_ready) begin
                    state          <= IDLE;
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb_exc_commit_ctrl: directed self-checking bench for exc_commit_ctrl
module tb_exc_commit_ctrl;
    logic        clk = 0, resetn = 0;
    logic        wb_valid = 0, wb_ertn = 0, crmd_ie = 0, redirect_ready = 0;
    logic [31:0] wb_pc = 0, wb_badv = 0, eentry_pc = 0, era_pc = 0;
    logic [4:0]  wb_exc = 0;
    logic [12:0] int_pending = 0;
    logic        wb_retire, csr_we_block, csr_ex, csr_ertn, csr_badv_we, flush, redirect_valid;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic [31:0] csr_ex_pc, csr_badv, redirect_pc;
    int checks = 0, errors = 0;

    exc_commit_ctrl dut (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc),
        .wb_badv(wb_badv), .wb_ertn(wb_ertn), .int_pending(int_pending), .crmd_ie(crmd_ie),
        .eentry_pc(eentry_pc), .era_pc(era_pc), .redirect_ready(redirect_ready),
        .wb_retire(wb_retire), .csr_we_block(csr_we_block), .csr_ex(csr_ex), .csr_ertn(csr_ertn),
        .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode), .csr_ex_pc(csr_ex_pc),
        .csr_badv_we(csr_badv_we), .csr_badv(csr_badv), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic clear_wb();
        wb_valid = 0; wb_ertn = 0; wb_exc = 0; int_pending = 0; wb_badv = 0;
    endtask

    // Inputs for the event must already be driven (just after a negedge).
    task automatic do_event(input string tag, input logic ex, input logic ertn, input logic [5:0] ec,
                            input logic bwe, input logic [31:0] bv, input logic [31:0] pc,
                            input logic [31:0] rpc, input int stall);
        int n;
        #1 chk({tag, "_retire"}, wb_retire, 0);
        @(negedge clk);
        chk({tag, "_ex"}, csr_ex, ex);
        chk({tag, "_ertn"}, csr_ertn, ertn);
        chk({tag, "_flush_ev"}, flush, 1);
        chk({tag, "_block"}, csr_we_block, 1);
        chk({tag, "_badv_we"}, csr_badv_we, bwe);
        if (ex) begin
            chk({tag, "_ecode"}, csr_ecode, ec);
            chk({tag, "_ex_pc"}, csr_ex_pc, pc);
            chk({tag, "_esub"}, csr_esubcode, 0);
        end
        if (bwe) chk({tag, "_badv"}, csr_badv, bv);
        clear_wb();
        eentry_pc = 32'hdead0000; era_pc = 32'hbeef0000;
        n = 0;
        while (!redirect_valid && n < 20) begin
            chk({tag, "_flush_dr"}, flush, 1);
            n++;
            @(negedge clk);
            chk({tag, "_pulse_off"}, {31'b0, csr_ex | csr_ertn}, 0);
        end
        chk({tag, "_drain_len"}, n, 3);
        chk({tag, "_rpc"}, redirect_pc, rpc);
        for (int i = 0; i < stall; i++) begin
            wb_valid = 1; wb_exc = 5'b00100; wb_pc = 32'h1c000100;
            #1 chk({tag, "_st_retire"}, wb_retire, 0);
            @(negedge clk);
            chk({tag, "_st_rv"}, redirect_valid, 1);
            chk({tag, "_st_rpc"}, redirect_pc, rpc);
            chk({tag, "_st_block"}, csr_we_block, 1);
            chk({tag, "_st_ex"}, csr_ex, 0);
        end
        clear_wb();
        redirect_ready = 1;
        @(negedge clk);
        redirect_ready = 0;
        chk({tag, "_rv_off"}, redirect_valid, 0);
        chk({tag, "_flush_off"}, flush, 0);
        chk({tag, "_unblock"}, csr_we_block, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_flush", flush, 0);
        chk("rst_rv", redirect_valid, 0);
        chk("rst_ex", csr_ex, 0);
        chk("rst_block", csr_we_block, 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_ecode", csr_ecode, 0);
        resetn = 1;
        @(negedge clk);

        wb_valid = 1; wb_pc = 32'h1c000010; wb_exc = 5'b00100; eentry_pc = 32'h1c008000;
        do_event("sys", 1, 0, 6'h0B, 0, 0, 32'h1c000010, 32'h1c008000, 0);

        wb_valid = 1; wb_pc = 32'h1c000020; wb_ertn = 1; era_pc = 32'h1c000014;
        do_event("ertn", 0, 1, 0, 0, 0, 0, 32'h1c000014, 0);

        wb_valid = 1; wb_pc = 32'h1c000030; wb_exc = 5'b10100; wb_badv = 32'h3; eentry_pc = 32'h1c008000;
        do_event("ale_sys", 1, 0, 6'h0B, 0, 0, 32'h1c000030, 32'h1c008000, 0);

        wb_valid = 1; wb_pc = 32'h1c000040; wb_exc = 5'b10000; wb_badv = 32'h3; eentry_pc = 32'h1c008000;
        do_event("ale", 1, 0, 6'h09, 1, 32'h3, 32'h1c000040, 32'h1c008000, 0);

        wb_valid = 1; wb_pc = 32'h1c000050; wb_exc = 5'b11111; wb_badv = 32'h1c000051; eentry_pc = 32'h1c008000;
        do_event("adef", 1, 0, 6'h08, 1, 32'h1c000051, 32'h1c000050, 32'h1c008000, 0);

        wb_valid = 1; wb_pc = 32'h1c000060; wb_exc = 5'b00110; eentry_pc = 32'h1c008000;
        do_event("ine", 1, 0, 6'h0D, 0, 0, 32'h1c000060, 32'h1c008000, 0);

        wb_valid = 1; wb_pc = 32'h1c000070; wb_exc = 5'b11000; eentry_pc = 32'h1c008000;
        do_event("brk", 1, 0, 6'h0C, 0, 0, 32'h1c000070, 32'h1c008000, 0);

        wb_valid = 1; wb_pc = 32'h1c000080; wb_ertn = 1; crmd_ie = 1; int_pending = 13'h800;
        eentry_pc = 32'h1c00c000; era_pc = 32'h1c000090;
        do_event("int", 1, 0, 6'h00, 0, 0, 32'h1c000080, 32'h1c00c000, 0);

        wb_valid = 1; wb_pc = 32'h1c0000a0; wb_ertn = 1; crmd_ie = 0; int_pending = 13'h800;
        era_pc = 32'h1c0000a4;
        do_event("int_off", 0, 1, 0, 0, 0, 0, 32'h1c0000a4, 0);

        wb_valid = 1; wb_pc = 32'h1c0000b0; wb_exc = 5'b00100; eentry_pc = 32'h1c008000;
        do_event("stall", 1, 0, 6'h0B, 0, 0, 32'h1c0000b0, 32'h1c008000, 5);

        wb_valid = 1; wb_pc = 32'h1c0000c0;
        #1 chk("retire", wb_retire, 1);
        @(negedge clk);
        chk("retire_flush", flush, 0);
        chk("retire_ex", csr_ex, 0);
        clear_wb();

        wb_valid = 1; wb_pc = 32'h1c0000d0; wb_exc = 5'b00100; eentry_pc = 32'h1c008000;
        @(negedge clk);
        clear_wb();
        @(negedge clk);
        chk("rd_in_drain", flush, 1);
        resetn = 0;
        #1;
        chk("rd_flush", flush, 0);
        chk("rd_rv", redirect_valid, 0);
        chk("rd_ex", csr_ex, 0);
        chk("rd_block", csr_we_block, 0);
        @(negedge clk);
        resetn = 1;
        wb_valid = 1; wb_pc = 32'h1c0000e0;
        #1 chk("rd_retire", wb_retire, 1);
        @(negedge clk);
        chk("rd_after_flush", flush, 0);
        clear_wb();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
